// File: rtl/uniboard_pwm_pkg.sv
// Shared constants and helpers for the uniboard PWM peripherals.
// All tick counts assume the 255 kHz PWM tick clock.
package uniboard_pwm_pkg;

  localparam int unsigned TICKS_PER_MS     = 255;
  localparam int unsigned FRAME_TICKS_20MS = 5100;
  localparam int unsigned PWM_NEUTRAL_8B   = 127;

  // Move current toward target by at most step, landing exactly on target when closer.
  // A step of 0 means no limiting: jump straight to target.
  function automatic int unsigned slew_next(input int unsigned current,
                                            input int unsigned target,
                                            input int unsigned step);
    if (step == 0) begin
      return target;
    end else if (target > current) begin
      return (target - current > step) ? current + step : target;
    end else begin
      return (current - target > step) ? current - step : target;
    end
  endfunction

endpackage

// File: rtl/multi_pwm_generator_if.sv
// Setpoint write bus from the motor peripheral's register decode to the PWM generator.
interface multi_pwm_generator_if #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned WIDTH    = 8
);
  localparam int unsigned ChanW = $clog2(CHANNELS) + 1;

  logic             wr_en;
  logic [ChanW-1:0] wr_chan;
  logic [WIDTH-1:0] wr_data;

  modport master (output wr_en, output wr_chan, output wr_data);
  modport slave  (input  wr_en, input  wr_chan, input  wr_data);

endinterface

// File: rtl/pwm_channel.sv
// One PWM output: setpoint register, per-frame (optionally slew-limited) active width,
// and a registered compare against the shared frame counter.
module pwm_channel
  import uniboard_pwm_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MIN_TICKS = TICKS_PER_MS,
  parameter int unsigned NEUTRAL   = PWM_NEUTRAL_8B,
  parameter int unsigned SLEW_STEP = 0,
  parameter int unsigned CNT_W     = 13
) (
  input  logic             clk_255kHz,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             boundary,
  input  logic             force_neutral,
  input  logic [CNT_W-1:0] count,
  output logic             pwm
);

  logic [WIDTH-1:0] setpoint_q, setpoint_d;
  logic [WIDTH-1:0] active_q, active_d;
  logic [WIDTH-1:0] target;
  logic             pwm_d;

  always_comb begin
    setpoint_d = wr_en ? wr_data : setpoint_q;
    // The boundary sees the pre-write setpoint; a same-cycle write lands next frame.
    target     = force_neutral ? WIDTH'(NEUTRAL) : setpoint_q;
    active_d   = active_q;
    if (boundary) begin
      active_d = WIDTH'(slew_next(32'(active_q), 32'(target), SLEW_STEP));
    end
    // Count 0 is the boundary itself; the pulse covers counts 1..MIN_TICKS+active.
    pwm_d = (count != '0) && (32'(count) <= MIN_TICKS + 32'(active_q));
  end

  always_ff @(posedge clk_255kHz or negedge reset) begin
    if (!reset) begin
      setpoint_q <= WIDTH'(NEUTRAL);
      active_q   <= WIDTH'(NEUTRAL);
      pwm        <= 1'b0;
    end else begin
      setpoint_q <= setpoint_d;
      active_q   <= active_d;
      pwm        <= pwm_d;
    end
  end

endmodule

// File: rtl/multi_pwm_generator.sv
// N-channel servo/ESC PWM generator: shared frame counter, command watchdog and write
// decode feeding one pwm_channel per output.
module multi_pwm_generator
  import uniboard_pwm_pkg::*;
#(
  parameter int unsigned CHANNELS       = 2,
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned MIN_TICKS      = TICKS_PER_MS,
  parameter int unsigned FRAME_TICKS    = FRAME_TICKS_20MS,
  parameter int unsigned NEUTRAL        = PWM_NEUTRAL_8B,
  parameter int unsigned SLEW_STEP      = 0,
  parameter int unsigned TIMEOUT_FRAMES = 25
) (
  input  logic                 clk_255kHz,
  input  logic                 reset,
  multi_pwm_generator_if.slave bus,
  input  logic                 pause,
  output logic [CHANNELS-1:0]  pwm,
  output logic                 frame_start,
  output logic                 timed_out
);

  localparam int unsigned CntW = $clog2(FRAME_TICKS);
  localparam int unsigned WdW  = (TIMEOUT_FRAMES > 0) ? $clog2(TIMEOUT_FRAMES + 1) : 1;

  logic [CntW-1:0]     count_q, count_d;
  logic [WdW-1:0]      wd_q, wd_d;
  logic                timed_out_q, timed_out_d;
  logic                frame_start_q;
  logic                boundary;
  logic                force_neutral;
  logic [CHANNELS-1:0] chan_wr;

  assign boundary = (count_q == '0);
  assign count_d  = (32'(count_q) == FRAME_TICKS - 1) ? '0 : count_q + CntW'(1);

  always_comb begin
    wd_d        = wd_q;
    timed_out_d = timed_out_q;
    if (bus.wr_en) begin
      // Any write, even to a nonexistent channel, counts as a sign of life.
      wd_d        = '0;
      timed_out_d = 1'b0;
    end else if (boundary && (TIMEOUT_FRAMES != 0) && (wd_q != WdW'(TIMEOUT_FRAMES))) begin
      wd_d        = wd_q + WdW'(1);
      timed_out_d = (wd_d == WdW'(TIMEOUT_FRAMES));
    end
  end

  // Use the next-state flag so the frame that trips the watchdog already goes neutral.
  assign force_neutral = pause | timed_out_d;

  always_comb begin
    chan_wr = '0;
    for (int i = 0; i < int'(CHANNELS); i++) begin
      chan_wr[i] = bus.wr_en && (32'(bus.wr_chan) == i);
    end
  end

  always_ff @(posedge clk_255kHz or negedge reset) begin
    if (!reset) begin
      count_q       <= '0;
      wd_q          <= '0;
      timed_out_q   <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      count_q       <= count_d;
      wd_q          <= wd_d;
      timed_out_q   <= timed_out_d;
      frame_start_q <= boundary;
    end
  end

  assign frame_start = frame_start_q;
  assign timed_out   = timed_out_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    pwm_channel #(
      .WIDTH    (WIDTH),
      .MIN_TICKS(MIN_TICKS),
      .NEUTRAL  (NEUTRAL),
      .SLEW_STEP(SLEW_STEP),
      .CNT_W    (CntW)
    ) u_chan (
      .clk_255kHz   (clk_255kHz),
      .reset        (reset),
      .wr_en        (chan_wr[i]),
      .wr_data      (bus.wr_data),
      .boundary     (boundary),
      .force_neutral(force_neutral),
      .count        (count_q),
      .pwm          (pwm[i])
    );
  end

endmodule

// File: tb/tb_multi_pwm_generator.sv
// Bench for multi_pwm_generator: two instances (no slew, slew 16) on one write bus, checked
// cycle by cycle against a frame-level model plus hand-computed directed sequences.
module tb_multi_pwm_generator;

  localparam int CH     = 2;
  localparam int W      = 8;
  localparam int MIN    = 10;
  localparam int FR     = 300;
  localparam int NEU    = 127;
  localparam int TO     = 8;
  localparam int STEP_A = 0;
  localparam int STEP_B = 16;

  logic          clk;
  logic          rst_n;
  logic          pause;
  logic [CH-1:0] pwm_a, pwm_b;
  logic          fs_a, fs_b, to_a, to_b;

  multi_pwm_generator_if #(.CHANNELS(CH), .WIDTH(W)) bus ();

  multi_pwm_generator #(
    .CHANNELS(CH), .WIDTH(W), .MIN_TICKS(MIN), .FRAME_TICKS(FR), .NEUTRAL(NEU),
    .SLEW_STEP(STEP_A), .TIMEOUT_FRAMES(TO)
  ) dut_a (
    .clk_255kHz(clk), .reset(rst_n), .bus(bus), .pause(pause),
    .pwm(pwm_a), .frame_start(fs_a), .timed_out(to_a)
  );

  multi_pwm_generator #(
    .CHANNELS(CH), .WIDTH(W), .MIN_TICKS(MIN), .FRAME_TICKS(FR), .NEUTRAL(NEU),
    .SLEW_STEP(STEP_B), .TIMEOUT_FRAMES(TO)
  ) dut_b (
    .clk_255kHz(clk), .reset(rst_n), .bus(bus), .pause(pause),
    .pwm(pwm_b), .frame_start(fs_b), .timed_out(to_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: setpoints are shared, active widths per instance.
  int sp[CH];
  int act[2][CH];
  int exp_w[2][CH];
  int hi_cnt[2][CH];
  int meas[2][CH];
  int fsw;
  bit m_to;
  int pos;
  int bad;
  int errors;
  int checks;

  typedef struct {
    bit wr;
    int ch;
    int dat;
    bit ps;
    int e0;
    int e1;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  function automatic int slew(input int cur, input int tgt, input int s);
    int d;
    d = tgt - cur;
    if (s == 0 || (d <= s && d >= -s)) return tgt;
    return (d > 0) ? cur + s : cur - s;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      sp[c] = NEU;
      for (int d = 0; d < 2; d++) act[d][c] = NEU;
    end
    fsw  = 0;
    m_to = 1'b0;
    pos  = 0;
  endtask

  // One clock edge: drive, advance the model by the rules, then compare every output.
  task automatic step(input bit we, input int ch, input int dat);
    bit            bnd;
    int            tgt;
    logic [CH-1:0] pv;
    logic          e;
    bus.wr_en   = we;
    bus.wr_chan = 2'(ch);
    bus.wr_data = 8'(dat);
    @(posedge clk);
    bnd = (pos == 0);
    if (we) fsw = 0;
    else if (bnd) fsw++;
    m_to = (TO > 0) && (fsw >= TO);
    if (bnd) begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < CH; c++) begin
          tgt = (pause || m_to) ? NEU : sp[c];
          act[d][c] = slew(act[d][c], tgt, (d == 0) ? STEP_A : STEP_B);
        end
      end
    end
    if (we && ch < CH) sp[ch] = dat;
    #1;
    for (int d = 0; d < 2; d++) begin
      pv = (d == 0) ? pwm_a : pwm_b;
      for (int c = 0; c < CH; c++) begin
        e = (pos >= 1) && (pos <= MIN + act[d][c]);
        if (pv[c] !== e) bad++;
        if (pv[c] === 1'b1) hi_cnt[d][c]++;
      end
    end
    if (fs_a !== bnd || fs_b !== bnd) bad++;
    if (to_a !== m_to || to_b !== m_to) bad++;
    pos = (pos + 1) % FR;
    bus.wr_en = 1'b0;
  endtask

  // One full frame starting at the boundary edge; pause changes just after the boundary.
  task automatic run_frame(input bit do_wr, input int ch, input int dat, input int wpos,
                           input bit nxt_pause);
    int bad0;
    bad0 = bad;
    for (int d = 0; d < 2; d++) for (int c = 0; c < CH; c++) hi_cnt[d][c] = 0;
    for (int p = 0; p < FR; p++) begin
      step(do_wr && (p == wpos), ch, dat);
      if (p == 0) begin
        pause = nxt_pause;
        for (int d = 0; d < 2; d++) for (int c = 0; c < CH; c++) exp_w[d][c] = MIN + act[d][c];
      end
    end
    for (int d = 0; d < 2; d++) begin
      for (int c = 0; c < CH; c++) begin
        meas[d][c] = hi_cnt[d][c];
        check($sformatf("model width dut%0d ch%0d", d, c), hi_cnt[d][c], exp_w[d][c]);
      end
    end
    check("cycle-level output mismatches", bad - bad0, 0);
  endtask

  initial begin
    int e;
    int bad0;
    errors = 0;
    checks = 0;
    bad    = 0;
    rst_n  = 1'b0;
    pause  = 1'b0;
    bus.wr_en   = 1'b0;
    bus.wr_chan = '0;
    bus.wr_data = '0;
    model_reset();

    tbl[0] = '{wr: 1, ch: 0, dat: 0,   ps: 0, e0: 10,  e1: 137};
    tbl[1] = '{wr: 1, ch: 1, dat: 255, ps: 0, e0: 10,  e1: 265};
    tbl[2] = '{wr: 1, ch: 0, dat: 10,  ps: 0, e0: 20,  e1: 265};
    tbl[3] = '{wr: 0, ch: 0, dat: 0,   ps: 1, e0: 137, e1: 137};
    tbl[4] = '{wr: 0, ch: 0, dat: 0,   ps: 1, e0: 137, e1: 137};
    tbl[5] = '{wr: 0, ch: 0, dat: 0,   ps: 0, e0: 20,  e1: 265};
    tbl[6] = '{wr: 1, ch: 2, dat: 50,  ps: 0, e0: 20,  e1: 265};
    tbl[7] = '{wr: 1, ch: 0, dat: 200, ps: 0, e0: 210, e1: 265};

    #3;
    check("reset outputs", {pwm_a, pwm_b, fs_a, fs_b, to_a, to_b}, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Defaults: neutral pulses on every channel.
    for (int k = 0; k < 3; k++) run_frame(0, 0, 0, 0, 0);
    check("default width a0", meas[0][0], 137);
    check("default width b1", meas[1][1], 137);

    // Slew up to full scale, keeping the watchdog fed via an out-of-range channel.
    run_frame(1, 0, 255, 100, 0);
    for (int k = 1; k <= 9; k++) begin
      run_frame(1, 2, 0, 100, 0);
      e = 127 + 16 * k;
      if (e > 255) e = 255;
      check($sformatf("slew up frame %0d", k), meas[1][0], MIN + e);
      check($sformatf("no slew frame %0d", k), meas[0][0], 265);
    end
    run_frame(1, 0, 0, 100, 0);
    for (int k = 1; k <= 3; k++) begin
      run_frame(1, 2, 0, 100, 0);
      check($sformatf("slew down frame %0d", k), meas[1][0], MIN + 255 - 16 * k);
      check($sformatf("no slew down frame %0d", k), meas[0][0], MIN);
    end

    // Table: each entry's write/pause shows up in the following frame.
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) run_frame(tbl[i].wr, tbl[i].ch, tbl[i].dat, 150, tbl[i].ps);
      else       run_frame(0, 0, 0, 0, 0);
      if (i > 0) begin
        check($sformatf("table %0d ch0", i - 1), meas[0][0], tbl[i - 1].e0);
        check($sformatf("table %0d ch1", i - 1), meas[0][1], tbl[i - 1].e1);
      end
    end

    // Write in the frame_start cycle, then write on the boundary edge itself.
    run_frame(1, 1, 40, 1, 0);
    check("write at frame_start, this frame", meas[0][1], 265);
    run_frame(0, 0, 0, 0, 0);
    check("write at frame_start, next frame", meas[0][1], 50);
    run_frame(1, 1, 60, 0, 0);
    check("write on boundary, this frame", meas[0][1], 50);
    run_frame(0, 0, 0, 0, 0);
    check("write on boundary, next frame", meas[0][1], 70);

    // Watchdog expiry and recovery.
    run_frame(1, 0, 200, 100, 0);
    for (int k = 1; k <= TO; k++) begin
      run_frame(0, 0, 0, 0, 0);
      check($sformatf("timed_out after %0d idle frames", k), to_a, (k >= TO) ? 1 : 0);
      check($sformatf("width after %0d idle frames", k), meas[0][0], (k < TO) ? 210 : 137);
    end
    run_frame(1, 0, 200, 100, 0);
    check("timed_out cleared by write", to_a, 0);
    check("width in write frame", meas[0][0], 137);
    run_frame(0, 0, 0, 0, 0);
    check("width after recovery", meas[0][0], 210);

    // Random writes, channels (including out of range), positions and pause.
    for (int f = 0; f < 15; f++) begin
      bit w;
      bit ps;
      w  = ($urandom_range(0, 3) != 0);
      ps = ($urandom_range(0, 3) == 0);
      run_frame(w, $urandom_range(0, 3), $urandom_range(0, 255), $urandom_range(0, FR - 1), ps);
    end
    pause = 1'b0;

    // Reset mid-pulse while timed out: outputs drop without a clock edge.
    for (int k = 0; k < 10 && !m_to; k++) run_frame(0, 0, 0, 0, 0);
    check("timed out before reset", to_a, 1);
    bad0 = bad;
    for (int k = 0; k < 5; k++) step(0, 0, 0);
    check("pre-reset cycle mismatches", bad - bad0, 0);
    check("pwm high before reset", {pwm_a, pwm_b}, 4'hF);
    #2;
    rst_n = 1'b0;
    #1;
    check("async reset outputs", {pwm_a, pwm_b, fs_a, fs_b, to_a, to_b}, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    run_frame(0, 0, 0, 0, 0);
    check("post-reset width a1", meas[0][1], 137);
    check("post-reset width b0", meas[1][0], 137);
    run_frame(0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_pwm_generator.md
# multi_pwm_generator

Parametrised N-channel servo/ESC PWM generator. It replaces the fixed two-channel 8-bit generator used by the motor peripheral. Each channel outputs a pulse of MIN_TICKS + setpoint ticks once per FRAME_TICKS-tick frame, with optional per-frame slew limiting, a pause input and a command watchdog that force all channels to neutral. It sits behind the motor peripheral's register decode and drives the drive-motor and auxiliary servo pins.

## Interface
- CHANNELS, 2: number of PWM outputs (1..16).
- WIDTH, 8: setpoint resolution in bits; full scale is 2^WIDTH-1.
- MIN_TICKS, 255: pulse length for setpoint 0 (1 ms at 255 kHz).
- FRAME_TICKS, 5100: frame period in ticks (20 ms). Requires MIN_TICKS + 2^WIDTH-1 < FRAME_TICKS.
- NEUTRAL, 127: reset, pause and timeout setpoint.
- SLEW_STEP, 0: maximum change of the active width per frame; 0 disables slew limiting.
- TIMEOUT_FRAMES, 25: frames without a write before timeout; 0 disables the watchdog.

Ports:
- clk_255kHz  in  1  sole clock, 255 kHz tick.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  one-cycle write strobe.
- wr_chan  in  $clog2(CHANNELS)+1  target channel.
- wr_data  in  WIDTH  new setpoint.
- pause  in  1  level; while high, all channels target NEUTRAL.
- pwm  out  CHANNELS  registered pulse outputs.
- frame_start  out  1  one-cycle pulse at the frame boundary (count==0).
- timed_out  out  1  watchdog expired.

## Operation
- Reset values (async assert): frame count 0, every setpoint = NEUTRAL, every active width = NEUTRAL, pwm = 0, frame_start = 0, timed_out = 0, watchdog = 0.
- Frame counter: counts 0..FRAME_TICKS-1, then wraps to 0. Width is $clog2(FRAME_TICKS).
- Write: on wr_en with wr_chan < CHANNELS, setpoint[wr_chan] <= wr_data. Writes with wr_chan >= CHANNELS are ignored, but still feed the watchdog.
- At each frame boundary, every channel computes its target:
  - NEUTRAL if pause or timed_out is high;
  - otherwise its setpoint.
- Active width update at the frame boundary:
  - SLEW_STEP==0: active = target.
  - Otherwise active moves toward target by min(SLEW_STEP, |target-active|). No overshoot. Use WIDTH+1-bit arithmetic so the result saturates at 0 and 2^WIDTH-1.
- Setpoints are retained through pause and timeout.
- Watchdog (TIMEOUT_FRAMES>0):
  - Counter increments at each frame boundary and saturates at TIMEOUT_FRAMES.
  - timed_out goes high when the counter reaches TIMEOUT_FRAMES.
  - Any wr_en clears the counter and timed_out on the next edge.
  - If a write and a frame boundary occur in the same cycle, the write wins: counter = 0.
- Simultaneous write and frame boundary: the boundary samples the pre-write setpoint. The new value applies from the next frame.

## Timing
- frame_start is high for exactly the one cycle in which count==0.
- pwm[i] rises on the edge after frame_start.
- pwm[i] stays high for exactly MIN_TICKS + active[i] cycles, then stays low for the rest of the frame.
- Period is exactly FRAME_TICKS cycles; all channels are phase-aligned.
- Latency from write to visible output change: one to two frames. The change appears in the first frame whose boundary follows the write edge.
- pause is sampled only at frame boundaries, so pause latency is at most one frame. Pulses already in progress are never truncated.
- Reset asserted mid-pulse: pwm goes low immediately, without waiting for a clock edge.
- After reset release, the first frame_start occurs on the first edge (count==0), followed by a NEUTRAL-width pulse.

## Structure
- Shared package uniboard_pwm_pkg holds:
  - TICKS_PER_MS = 255, FRAME_TICKS_20MS = 5100, PWM_NEUTRAL_8B = 127;
  - the slew step function (current, target, step) -> next.
- Sub-module pwm_channel, one instance per channel. It holds the setpoint and active registers, slew update and compare-to-count output register. The top level keeps the frame counter, watchdog and write decode.

## Test plan
- Release reset with no writes (defaults) -> both pwm high 382 cycles every 5100; frame_start period 5100; timed_out = 0 for frames 1..24.
- Write ch0=0, ch1=255 mid-frame -> next frame: pwm[0] high 255 cycles, pwm[1] high 510 cycles. Write on the frame_start cycle -> old width this frame, new width next frame.
- SLEW_STEP=16, write ch0=255 from 127 -> successive pulses of 398, 414, … 494, then 510 (saturates at the 8th frame, no overshoot); then write 0 -> widths fall by 16 per frame.
- No writes for 25 frames after writing ch0=200 -> timed_out high at the 25th frame_start, next pulse 382; a single write of 200 -> timed_out low on the next edge, next frame pulse 455.
- pause high after ch0=10 -> next frame pulse 382; setpoint retained; pause low -> pulse 265 the following frame.
- Write wr_chan=2 with CHANNELS=2 -> no output change, watchdog cleared. Assert reset mid-pulse -> pwm = 0 with no clock edge; all outputs at reset values.
